// File: rtl/conv_pkg.sv
// Types, constants and FSM state encoding shared by the conv window sequencer slice.
package conv_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SETTLE,
        EMIT,
        NEXT
    } seq_state_t;

    // Clamp to zero whenever the sign bit is set, so -0 maps to +0 as well.
    function automatic fp16_t fp16_relu(input fp16_t value);
        return value[15] ? FP16_ZERO : value;
    endfunction

endpackage

// File: rtl/window_extract.sv
// Combinational gather of one Size x Size x Depth window from the flattened feature map.
module window_extract
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int Depth      = 6,
    parameter int Size       = 5,
    parameter int InW        = 14,
    parameter int InH        = 14
) (
    input  logic [Depth*InH*InW*DATA_WIDTH-1:0]    image,
    input  logic [15:0]                            row,
    input  logic [15:0]                            col,
    output logic [Depth*Size*Size*DATA_WIDTH-1:0]  window
);

    localparam int ImgBits = Depth*InH*InW*DATA_WIDTH;
    localparam int SelW    = $clog2(ImgBits);

    for (genvar d = 0; d < Depth; d++) begin : g_d
        for (genvar r = 0; r < Size; r++) begin : g_r
            for (genvar c = 0; c < Size; c++) begin : g_c
                logic [SelW-1:0] src_bit;

                // Window element (d,r,c) reads image element (d, row+r, col+c).
                assign src_bit = SelW'(((d*InH + 32'(row) + r) * InW + 32'(col) + c) * DATA_WIDTH);
                assign window[((d*Size + r)*Size + c)*DATA_WIDTH +: DATA_WIDTH] =
                    image[src_bit +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Slides a conv window over the input map, drives the conv unit per window and streams results.
// Define CONV_SEQ_RELU_EN to clamp negative conv results to zero on the output stream.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int Depth       = 6,
    parameter int Size        = 5,
    parameter int InW         = 14,
    parameter int InH         = 14,
    parameter int ResultDelay = 2
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [Depth*InH*InW*DATA_WIDTH-1:0]               image,
    output logic [Depth*Size*Size*DATA_WIDTH-1:0]             conv_window,
    output logic                                              conv_reset,
    input  logic                                              conv_done,
    input  logic [DATA_WIDTH-1:0]                             conv_result,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [DATA_WIDTH-1:0]                             out_data,
    output logic [$clog2((InH-Size+1)*(InW-Size+1))-1:0]      out_index,
    output logic                                              busy,
    output logic                                              frame_done
);

    localparam int OutW = InW - Size + 1;
    localparam int OutH = InH - Size + 1;
    localparam int IdxW = $clog2(OutH*OutW);
    localparam int WinW = Depth*Size*Size*DATA_WIDTH;

    localparam logic [15:0] LastCol   = 16'(OutW - 1);
    localparam logic [15:0] LastRow   = 16'(OutH - 1);
    localparam logic [3:0]  DelayInit = 4'(ResultDelay);

    seq_state_t              state;
    logic [15:0]             row;
    logic [15:0]             col;
    logic [3:0]              delay_cnt;
    logic [WinW-1:0]         window_next;
    logic [DATA_WIDTH-1:0]   result_sel;
    logic                    last_pixel;

    window_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .Depth      (Depth),
        .Size       (Size),
        .InW        (InW),
        .InH        (InH)
    ) u_window_extract (
        .image  (image),
        .row    (row),
        .col    (col),
        .window (window_next)
    );

`ifdef CONV_SEQ_RELU_EN
    assign result_sel = DATA_WIDTH'(fp16_relu(fp16_t'(conv_result)));
`else
    assign result_sel = conv_result;
`endif

    assign last_pixel = (row == LastRow) && (col == LastCol);

    // Control outputs decode straight from the state register, so reset forces them at once.
    assign busy       = (state != IDLE);
    assign conv_reset = (state == IDLE) || (state == LOAD) || (state == NEXT);
    assign out_valid  = (state == EMIT);
    assign frame_done = (state == NEXT) && last_pixel;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the wide window register is reset too, keeping the conv bus at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            delay_cnt   <= '0;
            conv_window <= '0;
            out_data    <= '0;
            out_index   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        col   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    conv_window <= window_next;
                    state       <= RUN;
                end
                RUN: begin
                    if (conv_done) begin
                        delay_cnt <= DelayInit;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (delay_cnt == 4'd0) begin
                        out_data  <= result_sel;
                        out_index <= IdxW'(32'(row) * OutW + 32'(col));
                        state     <= EMIT;
                    end else begin
                        delay_cnt <= delay_cnt - 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (col < LastCol) begin
                        col <= col + 16'd1;
                    end else if (row < LastRow) begin
                        col <= '0;
                        row <= row + 16'd1;
                    end
                    state <= last_pixel ? IDLE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer with a small behavioural stand-in for the conv unit.
module tb_conv_window_sequencer;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int D  = 1;
    localparam int S  = 2;
    localparam int IW = 3;
    localparam int IH = 3;
    localparam int RD = 2;
    localparam int N  = D*S*S;

`ifdef CONV_SEQ_RELU_EN
    localparam logic [15:0] NegExpected = 16'h0000;
`else
    localparam logic [15:0] NegExpected = 16'hC400;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [D*IH*IW*DW-1:0]  image;
    logic [N*DW-1:0]        conv_window;
    logic                   conv_reset;
    logic                   conv_done;
    logic [DW-1:0]          conv_result;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [1:0]             out_index;
    logic                   busy;
    logic                   frame_done;

    logic [15:0]            filt;
    int                     mac_cnt;

    int errors   = 0;
    int checks   = 0;
    int fd_count = 0;
    int hs_count = 0;

    conv_window_sequencer #(
        .DATA_WIDTH  (DW),
        .Depth       (D),
        .Size        (S),
        .InW         (IW),
        .InH         (IH),
        .ResultDelay (RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .image       (image),
        .conv_window (conv_window),
        .conv_reset  (conv_reset),
        .conv_done   (conv_done),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Small integer to FP16 conversion, enough for window sums of +/-1.0 products.
    function automatic logic [15:0] int_to_fp16(input int v);
        int m;
        int e;
        if (v == 0) return 16'h0000;
        m = (v < 0) ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return {(v < 0), 5'(15 + e), 10'(m << (10 - e))};
    endfunction

    function automatic logic [15:0] mac_value();
        int sum;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            if (conv_window[i*DW +: DW] == FP16_ONE) begin
                if (filt == 16'h3C00) sum++;
                else if (filt == 16'hBC00) sum--;
            end
        end
        return int_to_fp16(sum);
    endfunction

    // Conv unit stand-in: done N+1 cycles after its reset is released.
    always @(posedge clk or posedge conv_reset) begin
        if (conv_reset) begin
            mac_cnt     <= 0;
            conv_done   <= 1'b0;
            conv_result <= 16'h0000;
        end else if (!conv_done) begin
            if (mac_cnt == N) begin
                conv_done   <= 1'b1;
                conv_result <= mac_value();
            end else begin
                mac_cnt <= mac_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (out_valid && out_ready) hs_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(hs_count >= target), 64'd1);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!(busy && !conv_reset && !out_valid) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(conv_reset), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input logic [15:0] exp_data);
        int fd0;
        int pix;
        int cyc;
        fd0 = fd_count;
        pix = 0;
        cyc = 0;
        pulse_start();
        while (busy && cyc < 300) begin
            tick();
            cyc++;
            if (out_valid) begin
                check("frame_data", 64'(out_data), 64'(exp_data));
                check("frame_index", 64'(out_index), 64'(pix));
                pix++;
            end
        end
        check("frame_pixels", 64'(pix), 64'd4);
        check("frame_done_count", 64'(fd_count - fd0), 64'd1);
        check("frame_busy_end", 64'(busy), 64'd0);
    endtask

    task automatic fill_ones();
        for (int i = 0; i < D*IH*IW; i++) image[i*DW +: DW] = FP16_ONE;
    endtask

    initial begin
        int          hs0;
        int          fd0;
        logic [15:0] d0;
        logic [1:0]  i0;
        logic        cr0;
        logic        stable;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        image     = '0;
        filt      = FP16_ONE;

        // Reset state
        repeat (3) tick();
        check("rst_conv_reset", 64'(conv_reset), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_conv_window", 64'(conv_window), 64'd0);
        reset = 1'b0;
        tick();

        // All-ones frame: every window sums to 4.0
        fill_ones();
        out_ready = 1'b1;
        run_frame(16'h4400);

        // Window gather with image element k holding raw value k
        for (int i = 0; i < D*IH*IW; i++) image[i*DW +: DW] = 16'(i);
        hs0 = hs_count;
        pulse_start();
        wait_run("win0_run");
        check("win0_e0", 64'(conv_window[0*DW +: DW]), 64'd0);
        check("win0_e1", 64'(conv_window[1*DW +: DW]), 64'd1);
        check("win0_e2", 64'(conv_window[2*DW +: DW]), 64'd3);
        check("win0_e3", 64'(conv_window[3*DW +: DW]), 64'd4);
        wait_hs("win3_hs", hs0 + 3);
        wait_run("win3_run");
        check("win3_e0", 64'(conv_window[0*DW +: DW]), 64'd4);
        check("win3_e1", 64'(conv_window[1*DW +: DW]), 64'd5);
        check("win3_e2", 64'(conv_window[2*DW +: DW]), 64'd7);
        check("win3_e3", 64'(conv_window[3*DW +: DW]), 64'd8);
        wait_idle("win_idle");

        // Backpressure on pixel 1
        fill_ones();
        fd0 = fd_count;
        hs0 = hs_count;
        pulse_start();
        wait_hs("bp_first_hs", hs0 + 1);
        out_ready = 1'b0;
        wait_valid("bp_valid");
        d0     = out_data;
        i0     = out_index;
        cr0    = conv_reset;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== d0 || out_index !== i0 || conv_reset !== cr0)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_index", 64'(out_index), 64'd1);
        check("bp_data", 64'(out_data), 64'h4400);
        check("bp_conv_reset", 64'(conv_reset), 64'd0);
        check("bp_no_advance", 64'(hs_count), 64'(hs0 + 1));
        out_ready = 1'b1;
        tick();
        wait_valid("bp_next_valid");
        check("bp_next_index", 64'(out_index), 64'd2);
        wait_idle("bp_idle");
        check("bp_frame_done", 64'(fd_count - fd0), 64'd1);

        // Reset mid-RUN of pixel 2, then restart
        fd0 = fd_count;
        hs0 = hs_count;
        pulse_start();
        wait_hs("mid_hs", hs0 + 2);
        wait_run("mid_run");
        tick();
        reset = 1'b1;
        tick();
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_conv_reset", 64'(conv_reset), 64'd1);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_no_frame_done", 64'(fd_count), 64'(fd0));
        reset = 1'b0;
        tick();
        pulse_start();
        wait_valid("restart_valid");
        check("restart_index", 64'(out_index), 64'd0);
        wait_idle("restart_idle");

        // Negative filter: -4.0 per window, clamped when the ReLU is built in
        filt = 16'hBC00;
        run_frame(NegExpected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
